// File: rtl/stream_arb_2to1.sv
// rtl/stream_arb_2to1.sv - two-source packet arbiter merging weight and feature streams
//
// Merges two packetised streams (s0 = weights, s1 = features) onto one output
// feeding the 1536->3072 packer. A source that wins arbitration owns the output
// until it delivers an accepted beat with tlast; only then does the arbiter
// return to IDLE and re-arbitrate. Ties are broken round-robin against the
// source that was granted most recently.
//
// Optional feature (macro ARB_PAIR_PAD_EN):
//   When defined, packets with an odd number of accepted beats are extended
//   with one all-zero beat so every output packet pairs up cleanly in the
//   3072-bit packer. The source's final beat is forwarded with tlast cleared
//   and the pad beat carries tlast. When undefined, the PAD state and all
//   padding logic are absent and tlast passes through untouched.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s0_axis_*, s0_weight_switch  source 0 stream (weights) + sideband
//   s1_axis_*, s1_weight_switch  source 1 stream (features) + sideband
//   m_axis_*, m_weight_switch    merged output stream + sideband
//   grant_id                     source that currently owns (or last owned) the output
//   busy                         high whenever the arbiter is not in IDLE

module stream_arb_2to1 #(
  parameter int DATA_WIDTH = 1536
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  input  logic                  s0_axis_tlast,
  output logic                  s0_axis_tready,
  input  logic                  s0_weight_switch,

  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  input  logic                  s1_axis_tlast,
  output logic                  s1_axis_tready,
  input  logic                  s1_weight_switch,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  m_weight_switch,

  output logic                  grant_id,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;
  localparam logic [1:0] ST_PAD    = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;

  // Source granted most recently; resets to 1 so s0 wins the first tie.
  logic last_grant;
  // Accepted-beat parity of the current packet (0 = even count so far).
  logic parity;

  // Muxed view of whichever source is granted.
  logic                  granted;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic                  sel_tvalid;
  logic                  sel_tlast;
  logic                  sel_ws;
  logic                  beat_acc;
  logic                  pkt_end;

`ifdef ARB_PAIR_PAD_EN
  // weight_switch of the most recent accepted source beat, replayed on the pad beat.
  logic pad_ws;
  // Final beat of a packet whose total beat count would be odd.
  logic odd_close;
`endif

  assign granted    = (state == ST_GRANT0) || (state == ST_GRANT1);
  assign sel_tdata  = (state == ST_GRANT1) ? s1_axis_tdata    : s0_axis_tdata;
  assign sel_tvalid = (state == ST_GRANT1) ? s1_axis_tvalid   : s0_axis_tvalid;
  assign sel_tlast  = (state == ST_GRANT1) ? s1_axis_tlast    : s0_axis_tlast;
  assign sel_ws     = (state == ST_GRANT1) ? s1_weight_switch : s0_weight_switch;

  assign beat_acc = granted && sel_tvalid && m_axis_tready;
  assign pkt_end  = beat_acc && sel_tlast;

`ifdef ARB_PAIR_PAD_EN
  // parity==0 before this beat means this beat makes the count odd.
  assign odd_close = granted && sel_tlast && !parity;
`endif

  assign busy = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Output datapath: zero-latency pass-through of the granted source.
  // ---------------------------------------------------------------------------
  always_comb begin
    m_axis_tdata    = '0;
    m_axis_tvalid   = 1'b0;
    m_axis_tlast    = 1'b0;
    m_weight_switch = 1'b0;
    s0_axis_tready  = 1'b0;
    s1_axis_tready  = 1'b0;

    case (state)
      ST_GRANT0: begin
        m_axis_tdata    = s0_axis_tdata;
        m_axis_tvalid   = s0_axis_tvalid;
        m_axis_tlast    = s0_axis_tlast;
        m_weight_switch = s0_weight_switch;
        s0_axis_tready  = m_axis_tready;
      end
      ST_GRANT1: begin
        m_axis_tdata    = s1_axis_tdata;
        m_axis_tvalid   = s1_axis_tvalid;
        m_axis_tlast    = s1_axis_tlast;
        m_weight_switch = s1_weight_switch;
        s1_axis_tready  = m_axis_tready;
      end
`ifdef ARB_PAIR_PAD_EN
      ST_PAD: begin
        // Zero pad beat closes the packet; sources are held off meanwhile.
        m_axis_tvalid   = 1'b1;
        m_axis_tlast    = 1'b1;
        m_weight_switch = pad_ws;
      end
`endif
      default: begin
      end
    endcase

`ifdef ARB_PAIR_PAD_EN
    // The pad beat will carry tlast instead of the source's odd final beat.
    if (odd_close) begin
      m_axis_tlast = 1'b0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        // Tie goes to the source that did not win last time.
        if (s0_axis_tvalid && (!s1_axis_tvalid || last_grant)) begin
          state_nxt = ST_GRANT0;
        end else if (s1_axis_tvalid) begin
          state_nxt = ST_GRANT1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        // A source dropping tvalid mid-packet keeps the grant; only an
        // accepted tlast beat ends ownership.
        if (pkt_end) begin
`ifdef ARB_PAIR_PAD_EN
          state_nxt = parity ? ST_IDLE : ST_PAD;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef ARB_PAIR_PAD_EN
      ST_PAD: begin
        if (m_axis_tready) begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      parity     <= 1'b0;
      grant_id   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && (state_nxt == ST_GRANT0)) begin
        last_grant <= 1'b0;
        grant_id   <= 1'b0;
        parity     <= 1'b0;
      end else if ((state == ST_IDLE) && (state_nxt == ST_GRANT1)) begin
        last_grant <= 1'b1;
        grant_id   <= 1'b1;
        parity     <= 1'b0;
      end else if (beat_acc) begin
        parity <= ~parity;
      end
    end
  end

`ifdef ARB_PAIR_PAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_ws <= 1'b0;
    end else if (beat_acc) begin
      pad_ws <= sel_ws;
    end
  end
`endif

endmodule

// File: tb/tb_stream_arb_2to1.sv
// tb/tb_stream_arb_2to1.sv - scoreboard bench for stream_arb_2to1
module tb_stream_arb_2to1;

  localparam int DW = 1536;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s0_axis_tdata;
  logic          s0_axis_tvalid;
  logic          s0_axis_tlast;
  logic          s0_axis_tready;
  logic          s0_weight_switch;
  logic [DW-1:0] s1_axis_tdata;
  logic          s1_axis_tvalid;
  logic          s1_axis_tlast;
  logic          s1_axis_tready;
  logic          s1_weight_switch;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          m_weight_switch;
  logic          grant_id;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        ws;
    logic        gid;
  } beat_t;

  beat_t exp_q[$];

  stream_arb_2to1 #(.DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s0_axis_tdata    (s0_axis_tdata),
    .s0_axis_tvalid   (s0_axis_tvalid),
    .s0_axis_tlast    (s0_axis_tlast),
    .s0_axis_tready   (s0_axis_tready),
    .s0_weight_switch (s0_weight_switch),
    .s1_axis_tdata    (s1_axis_tdata),
    .s1_axis_tvalid   (s1_axis_tvalid),
    .s1_axis_tlast    (s1_axis_tlast),
    .s1_axis_tready   (s1_axis_tready),
    .s1_weight_switch (s1_weight_switch),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tready    (m_axis_tready),
    .m_weight_switch  (m_weight_switch),
    .grant_id         (grant_id),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] got, input logic [63:0] exp);
    logic [DW-1:0] e;
    e = '0;
    e[63:0] = exp;
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got[63:0], exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  task automatic push(input logic [63:0] d, input logic last, input logic ws, input logic gid);
    beat_t b;
    b.data = d;
    b.last = last;
    b.ws   = ws;
    b.gid  = gid;
    exp_q.push_back(b);
  endtask

  // Wait until the given source is ready, then step past the accepting edge.
  task automatic wait_acc(input int src);
    int   n;
    logic rdy;
    n = 0;
    @(negedge clk);
    rdy = (src == 0) ? s0_axis_tready : s1_axis_tready;
    while (!rdy && n < 300) begin
      @(negedge clk);
      n++;
      rdy = (src == 0) ? s0_axis_tready : s1_axis_tready;
    end
    if (!rdy) fail_now((src == 0) ? "s0_accept" : "s1_accept");
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int src, input logic [63:0] base, input int n, input logic ws_last);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = '0;
      d[63:0] = base + 64'(i);
      if (src == 0) begin
        s0_axis_tdata    = d;
        s0_axis_tvalid   = 1'b1;
        s0_axis_tlast    = (i == n - 1);
        s0_weight_switch = (i == n - 1) && ws_last;
      end else begin
        s1_axis_tdata    = d;
        s1_axis_tvalid   = 1'b1;
        s1_axis_tlast    = (i == n - 1);
        s1_weight_switch = (i == n - 1) && ws_last;
      end
      wait_acc(src);
    end
    if (src == 0) begin
      s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0; s0_weight_switch = 1'b0;
    end else begin
      s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0; s1_weight_switch = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now(name);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard for every beat presented with ready, and
  // checks the bubble cycle after every packet-closing beat.
  initial begin
    beat_t e;
    logic  prev_last;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_last = 1'b0;
      end else begin
        if (prev_last) chk1("bubble_after_tlast", m_axis_tvalid, 1'b0);
        prev_last = 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none at %0t", m_axis_tdata[63:0], $time);
          end else begin
            e = exp_q.pop_front();
            chkd("m_tdata", m_axis_tdata, e.data);
            chk1("m_tlast", m_axis_tlast, e.last);
            chk1("m_weight_switch", m_weight_switch, e.ws);
            chk1("grant_id", grant_id, e.gid);
          end
          prev_last = m_axis_tlast;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    s0_axis_tdata    = '0; s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0; s0_weight_switch = 1'b0;
    s1_axis_tdata    = '0; s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0; s1_weight_switch = 1'b0;
    m_axis_tready    = 1'b1;

    // Reset state
    #12;
    chk1("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk1("rst_s0_tready", s0_axis_tready, 1'b0);
    chk1("rst_s1_tready", s1_axis_tready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_grant_id", grant_id, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // s0 alone, 4 beats
    push(64'h1, 0, 0, 0); push(64'h2, 0, 0, 0); push(64'h3, 0, 0, 0); push(64'h4, 1, 0, 0);
    fork
      send(0, 64'h1, 4, 1'b0);
      begin
        for (int i = 0; i < 7; i++) begin
          @(negedge clk);
          chk1("s1_tready_during_s0", s1_axis_tready, 1'b0);
        end
      end
    join
    drain("drain_s0_only");

    // Both sources valid straight out of reset: s0, bubble, s1, s0
    apply_reset();
    push(64'h10, 0, 0, 0); push(64'h11, 1, 0, 0);
    push(64'h20, 0, 0, 1); push(64'h21, 1, 0, 1);
    push(64'h12, 0, 0, 0); push(64'h13, 1, 0, 0);
    fork
      begin
        send(0, 64'h10, 2, 1'b0);
        send(0, 64'h12, 2, 1'b0);
      end
      send(1, 64'h20, 2, 1'b0);
    join
    drain("drain_round_robin");

    // s1 packet with a 3-cycle output stall mid-packet
    push(64'h30, 0, 0, 1); push(64'h31, 0, 0, 1); push(64'h32, 0, 0, 1); push(64'h33, 1, 0, 1);
    fork
      send(1, 64'h30, 4, 1'b0);
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!(m_axis_tvalid && m_axis_tdata[7:0] == 8'h31) && n < 300) begin
          @(negedge clk);
          n++;
        end
        if (n >= 300) fail_now("stall_wait");
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk1("stall_s1_tready", s1_axis_tready, 1'b0);
          chk1("stall_m_tvalid", m_axis_tvalid, 1'b1);
          chkd("stall_m_tdata", m_axis_tdata, 64'h32);
          @(posedge clk);
          #1;
        end
        m_axis_tready = 1'b1;
      end
    join
    drain("drain_stall");

    // s1 odd packet, weight_switch on final beat
`ifdef ARB_PAIR_PAD_EN
    push(64'h41, 0, 0, 1); push(64'h42, 0, 0, 1); push(64'h43, 0, 1, 1); push(64'h0, 1, 1, 1);
`else
    push(64'h41, 0, 0, 1); push(64'h42, 0, 0, 1); push(64'h43, 1, 1, 1);
`endif
    send(1, 64'h41, 3, 1'b1);
    drain("drain_odd");

    // Asynchronous reset during beat 2 of an s0 packet
    push(64'h51, 0, 0, 0); push(64'h52, 0, 0, 0);
    s0_axis_tdata = '0;
    s0_axis_tdata[7:0] = 8'h51;
    s0_axis_tvalid = 1'b1;
    s0_axis_tlast  = 1'b0;
    wait_acc(0);
    s0_axis_tdata[7:0] = 8'h52;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk1("async_rst_s0_tready", s0_axis_tready, 1'b0);
    chk1("async_rst_s1_tready", s1_axis_tready, 1'b0);
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_grant_id", grant_id, 1'b0);
    chk1("async_rst_queue", 1'(exp_q.size() == 0), 1'b1);
    exp_q.delete();
    s0_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Post-reset tie: s0 wins; its 1-beat packet starts at parity 0
`ifdef ARB_PAIR_PAD_EN
    push(64'h60, 0, 0, 0); push(64'h0, 1, 0, 0);
`else
    push(64'h60, 1, 0, 0);
`endif
    push(64'h70, 0, 0, 1); push(64'h71, 1, 0, 1);
    fork
      send(0, 64'h60, 1, 1'b0);
      send(1, 64'h70, 2, 1'b0);
    join
    drain("drain_post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_arb_2to1.md
STREAM_ARB_2TO1 -- requirements
Module: stream_arb_2to1

Interface
REQ-001 Parameter DATA_WIDTH, default 1536: payload width of every tdata port.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 s0_axis_tdata/tvalid/tlast  input  DATA_WIDTH/1/1  AXIS source 0 (weights).
REQ-005 s0_axis_tready  output  1  source 0 accept.
REQ-006 s0_weight_switch  input  1  sideband, qualified by s0 beat.
REQ-007 s1_axis_tdata/tvalid/tlast  input  DATA_WIDTH/1/1  AXIS source 1 (features).
REQ-008 s1_axis_tready  output  1  source 1 accept.
REQ-009 s1_weight_switch  input  1  sideband, qualified by s1 beat.
REQ-010 m_axis_tdata/tvalid/tlast  output  DATA_WIDTH/1/1  merged stream to the 1536->3072 packer.
REQ-011 m_axis_tready  input  1  packer accept.
REQ-012 m_weight_switch  output  1  sideband of the current output beat.
REQ-013 grant_id  output  1  source currently owning the output; busy  output  1  high in any non-IDLE state.

Function
REQ-014 FSM states SHALL be IDLE, GRANT0, GRANT1, PAD.
REQ-015 IDLE: m_axis_tvalid=0, both treadys=0; next state decided from registered last_grant and current tvalids.
REQ-016 IDLE arbitration: only s0 valid -> GRANT0; only s1 valid -> GRANT1; both -> the source != last_grant; none -> stay IDLE.
REQ-017 Entering GRANTx SHALL set last_grant=x and grant_id=x.
REQ-018 GRANTx: m_axis_tdata/tvalid/tlast/m_weight_switch SHALL be combinational copies of sx; sx_tready = m_axis_tready; other source tready=0.
REQ-019 Beat accepted when sx_tvalid & m_axis_tready in GRANTx; beat parity bit toggles per accepted beat, cleared on entering GRANTx.
REQ-020 Grant held until accepted beat with sx_tlast=1; source tvalid dropping mid-packet SHALL not release the grant (m_axis_tvalid follows 0).
REQ-021 Accepted tlast beat (no padding needed) -> IDLE; one bubble cycle between packets even if other source waits.
REQ-022 Requests from the non-granted source SHALL be ignored until IDLE.
REQ-023 Data path latency 0 cycles; arbitration latency 1 cycle (IDLE) per packet.
REQ-024 PAD: m_axis_tvalid=1, tdata=0, tlast=1, m_weight_switch=latched weight_switch of the last source beat; both source treadys=0; leave to IDLE on m_axis_tready.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, last_grant=1 (s0 wins first tie), parity=0, grant_id=0, busy=0, m_axis_tvalid=0, both treadys=0.
REQ-026 Reset mid-packet SHALL abandon the packet; no padding beat emitted; first post-reset packet starts clean.

Configuration
REQ-027 Macro ARB_PAIR_PAD_EN defined: a packet whose accepted beat count is odd SHALL have its final beat forwarded with m_axis_tlast forced 0, then enter PAD, so every output packet has an even beat count for the 3072-bit packer.
REQ-028 Macro ARB_PAIR_PAD_EN undefined: PAD state and padding logic absent; tlast always passes through unchanged; odd packets forwarded as is.

Verification
REQ-029 Only s0 sends 4 beats (tdata 1..4, tlast on 4), m_axis_tready=1 -> 4 output beats, 1..4, tlast on beat 4, grant_id=0, s1_tready=0 throughout.
REQ-030 s0 and s1 both valid with 2-beat packets from cycle 0 after reset -> order s0 packet, 1 IDLE cycle, s1 packet, then s0 again (round-robin).
REQ-031 GRANT1, m_axis_tready low for 3 cycles mid-packet -> s1_tready low for those 3 cycles, beat held stable, no beat lost or duplicated.
REQ-032 ARB_PAIR_PAD_EN defined, s1 sends 3 beats with weight_switch=1 on beat 3 -> output beats 1,2,3 (tlast 0), then zero beat with tlast=1, m_weight_switch=1; total 4 beats. Undefined -> 3 beats, tlast on beat 3.
REQ-033 rst_n asserted asynchronously during beat 2 of a 4-beat s0 packet -> m_axis_tvalid and treadys 0 without waiting for clk; after release, s0 tie wins, new packet starts with parity 0.
